conv_out_postproc: RTL and testbench
====================================

CONV_OUT_POSTPROC -- requirements
Module: conv_out_postproc

Interface
REQ-001 SHALL have parameters: RESULT_WIDTH, default 48, accumulator width; PIXEL_WIDTH, default 16, output pixel width; FRAC_SHIFT, default 8, fractional bits removed; ADDR_WIDTH, default 14, noise address width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports s_axis_tdata (input, RESULT_WIDTH, signed accumulator), s_axis_tvalid (input, 1), s_axis_tlast (input, 1, last beat of frame) and s_axis_tready (output, 1).
REQ-005 SHALL have ports noise_addr (output, ADDR_WIDTH, noise BRAM read address), noise_en (output, 1, BRAM read enable) and noise_data (input, 16, signed, valid 1 cycle after an enabled read).
REQ-006 SHALL have port noise_scale, input, 16, signed Q8.8 noise gain, held static during a frame.
REQ-007 SHALL have ports m_axis_tdata (output, PIXEL_WIDTH, signed), m_axis_tvalid (output, 1), m_axis_tlast (output, 1) and m_axis_tready (input, 1).
REQ-008 SHALL have ports frame_done (output, 1, one-cycle pulse) and sat_count (output, 16, saturation event count).

Function
REQ-009 SHALL implement a 3-stage pipeline: S0 accept beat and issue noise read, S1 round/shift and add noise, S2 leaky-ReLU and saturate into the output register.
REQ-010 SHALL give 3-cycle latency from s_axis handshake to m_axis_tvalid with m_axis_tready held high.
REQ-011 SHALL define stall = m_axis_tvalid AND NOT m_axis_tready; on stall, every stage and the noise_data capture hold and noise_en is 0.
REQ-012 SHALL drive s_axis_tready = NOT stall, so a full pipeline sustains one beat per cycle.
REQ-013 SHALL keep m_axis_tdata/m_axis_tlast stable while m_axis_tvalid is 1 and m_axis_tready is 0.
REQ-014 SHALL compute r = (s_axis_tdata + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, arithmetic, at full RESULT_WIDTH.
REQ-015 SHALL compute n = (noise_data * noise_scale) >>> 8 as a signed 32-bit product, sign-extend it, and form v = r + n.
REQ-016 SHALL output v unchanged for v >= 0 and (v*13) >>> 6 (floor) for v < 0.
REQ-017 SHALL saturate the S2 result to [-2^(PIXEL_WIDTH-1), 2^(PIXEL_WIDTH-1)-1].
REQ-018 SHALL increment sat_count by 1 per saturated output handshake, sticking at 0xFFFF.
REQ-019 SHALL pulse noise_en on each accepted s_axis beat with noise_addr equal to the beat index, then increment noise_addr.
REQ-020 SHALL set noise_addr to 0 after the beat carrying s_axis_tlast is accepted, and wrap it from 2^ADDR_WIDTH-1 to 0.
REQ-021 SHALL carry tlast through the pipeline aligned with its data.
REQ-022 SHALL assert frame_done for exactly the cycle the m_axis handshake with m_axis_tlast=1 occurs.
REQ-023 SHALL, when s_axis and m_axis handshakes occur in the same cycle, shift the pipeline with no bubble and no loss.

Reset
REQ-024 SHALL, while Reset=0, clear all stage valids, noise_addr, sat_count, m_axis_tdata, m_axis_tlast, m_axis_tvalid, noise_en and frame_done to 0 immediately.
REQ-025 SHALL drop in-flight beats on reset mid-frame and resume with noise_addr 0; s_axis_tready SHALL be 1 on the first cycle after release.

Configuration
REQ-026 SHALL, with macro CONV_POSTPROC_NOISE_EN defined, implement REQ-005/006/015/019/020 noise addressing and addition as specified.
REQ-027 SHALL, without CONV_POSTPROC_NOISE_EN, set n = 0, tie noise_en and noise_addr to 0, ignore noise_data and noise_scale, and leave latency unchanged at 3.

Verification
REQ-028 SHALL test: tdata=25600, noise_data=0, tready=1 -> m_axis_tdata=100 exactly 3 cycles after the handshake.
REQ-029 SHALL test: tdata=-25600, noise 0 -> m_axis_tdata=-21; tdata=2^40 -> 32767 with sat_count 0->1.
REQ-030 SHALL test (noise enabled): tdata=0, noise_data=256, noise_scale=512 -> m_axis_tdata=512, with noise_en pulse and noise_addr=0 on that read.
REQ-031 SHALL test: 4-frame beats with tlast on beat 4 -> m_axis_tlast and frame_done on the 4th output only, then noise_addr=0.
REQ-032 SHALL test: 8 beats sent with m_axis_tready low for 5 cycles -> s_axis_tready drops while stalled, all 8 outputs emerge in order, none duplicated.
REQ-033 SHALL test: Reset asserted with 3 beats in flight -> all outputs 0 at once, no stale beat emitted after release.

Source files
------------

// File: rtl/conv_out_postproc.sv
// Convolution output post-processor: round/shift, optional noise injection, leaky-ReLU, saturation.
// Define CONV_POSTPROC_NOISE_EN to enable the noise BRAM read path; otherwise noise contributes zero.
module conv_out_postproc #(
   parameter int RESULT_WIDTH = 48,
   parameter int PIXEL_WIDTH  = 16,
   parameter int FRAC_SHIFT   = 8,
   parameter int ADDR_WIDTH   = 14
) (
   input  logic                           clk,
   input  logic                           Reset,
   input  logic signed [RESULT_WIDTH-1:0] s_axis_tdata,
   input  logic                           s_axis_tvalid,
   input  logic                           s_axis_tlast,
   output logic                           s_axis_tready,
   output logic [ADDR_WIDTH-1:0]          noise_addr,
   output logic                           noise_en,
   input  logic signed [15:0]             noise_data,
   input  logic signed [15:0]             noise_scale,
   output logic signed [PIXEL_WIDTH-1:0]  m_axis_tdata,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tlast,
   input  logic                           m_axis_tready,
   output logic                           frame_done,
   output logic [15:0]                    sat_count
);

   localparam int EXT_W = RESULT_WIDTH + 4;
   localparam logic signed [RESULT_WIDTH-1:0] ROUND_BIAS = RESULT_WIDTH'(longint'(1) <<< (FRAC_SHIFT - 1));
   localparam logic signed [EXT_W-1:0] PIX_MAX  = EXT_W'((longint'(1) <<< (PIXEL_WIDTH - 1)) - 1);
   localparam logic signed [EXT_W-1:0] PIX_MIN  = EXT_W'(-(longint'(1) <<< (PIXEL_WIDTH - 1)));
   localparam logic signed [EXT_W-1:0] LEAK_MUL = EXT_W'(13);

   logic stall;
   logic accept;

   logic                           s0_valid_reg, s0_last_reg;
   logic signed [RESULT_WIDTH-1:0] s0_data_reg;
   logic                           s1_valid_reg, s1_last_reg;
   logic signed [RESULT_WIDTH-1:0] s1_v_reg;
   logic                           m_sat_reg;

   logic signed [RESULT_WIDTH-1:0] round_val, noise_term, sum_val;
   logic signed [EXT_W-1:0]        v_ext, leak_val, act_val;
   logic signed [PIXEL_WIDTH-1:0]  pix_next;
   logic                           sat_next;

   assign stall         = m_axis_tvalid & ~m_axis_tready;
   assign s_axis_tready = ~stall;
   assign accept        = s_axis_tvalid & ~stall;
   assign frame_done    = m_axis_tvalid & m_axis_tready & m_axis_tlast;

`ifdef CONV_POSTPROC_NOISE_EN
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  rd_pending_reg;
   logic signed [15:0]    noise_hold_reg, noise_sel;
   logic signed [31:0]    noise_prod;

   // BRAM data is only present the cycle after the read; hold it if S1 is stalled then.
   assign noise_sel  = rd_pending_reg ? noise_data : noise_hold_reg;
   assign noise_prod = 32'(noise_sel) * 32'(noise_scale);
   assign noise_term = RESULT_WIDTH'(noise_prod >>> 8);
   assign noise_addr = addr_reg;
   assign noise_en   = accept & Reset;

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         addr_reg       <= '0;
         rd_pending_reg <= 1'b0;
         noise_hold_reg <= '0;
      end else begin
         rd_pending_reg <= accept;
         noise_hold_reg <= noise_sel;
         if (accept)
            addr_reg <= s_axis_tlast ? '0 : addr_reg + 1'b1;
      end
   end
`else
   logic unused_noise;

   assign unused_noise = ^{noise_data, noise_scale};
   assign noise_term   = '0;
   assign noise_addr   = '0;
   assign noise_en     = 1'b0;
`endif

   assign round_val = (s0_data_reg + ROUND_BIAS) >>> FRAC_SHIFT;
   assign sum_val   = round_val + noise_term;

   // Widened so the x13 leak on large negative values cannot wrap before saturation.
   always_comb begin
      v_ext    = EXT_W'(s1_v_reg);
      leak_val = (v_ext * LEAK_MUL) >>> 6;
      act_val  = s1_v_reg[RESULT_WIDTH-1] ? leak_val : v_ext;
      sat_next = 1'b0;
      pix_next = PIXEL_WIDTH'(act_val);
      if (act_val > PIX_MAX) begin
         pix_next = PIXEL_WIDTH'(PIX_MAX);
         sat_next = 1'b1;
      end else if (act_val < PIX_MIN) begin
         pix_next = PIXEL_WIDTH'(PIX_MIN);
         sat_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         s0_valid_reg  <= 1'b0;
         s0_last_reg   <= 1'b0;
         s0_data_reg   <= '0;
         s1_valid_reg  <= 1'b0;
         s1_last_reg   <= 1'b0;
         s1_v_reg      <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         m_sat_reg     <= 1'b0;
      end else if (!stall) begin
         s0_valid_reg  <= s_axis_tvalid;
         s0_last_reg   <= s_axis_tvalid & s_axis_tlast;
         s0_data_reg   <= s_axis_tdata;
         s1_valid_reg  <= s0_valid_reg;
         s1_last_reg   <= s0_last_reg;
         s1_v_reg      <= sum_val;
         m_axis_tvalid <= s1_valid_reg;
         m_axis_tlast  <= s1_last_reg;
         m_axis_tdata  <= pix_next;
         m_sat_reg     <= s1_valid_reg & sat_next;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset)
         sat_count <= '0;
      else if (m_axis_tvalid && m_axis_tready && m_sat_reg && sat_count != 16'hFFFF)
         sat_count <= sat_count + 16'd1;
   end

endmodule

// File: tb/tb_conv_out_postproc.sv
// Randomized self-checking bench for conv_out_postproc with a behavioural reference model.
// Noise checks follow the same CONV_POSTPROC_NOISE_EN define as the design.
module tb_conv_out_postproc;
   localparam int RW = 48;
   localparam int PW = 16;
   localparam int FS = 8;
   localparam int AW = 14;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic signed [RW-1:0] s_data = '0;
   logic                 s_valid = 1'b0;
   logic                 s_last = 1'b0;
   logic                 s_ready;
   logic [AW-1:0]        noise_addr;
   logic                 noise_en;
   logic signed [15:0]   noise_data = '0;
   logic signed [15:0]   noise_scale = '0;
   logic signed [PW-1:0] m_data;
   logic                 m_valid, m_last;
   logic                 m_ready = 1'b1;
   logic                 frame_done;
   logic [15:0]          sat_count;

   conv_out_postproc #(.RESULT_WIDTH(RW), .PIXEL_WIDTH(PW), .FRAC_SHIFT(FS), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .Reset(rst_n),
      .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
      .noise_addr(noise_addr), .noise_en(noise_en), .noise_data(noise_data), .noise_scale(noise_scale),
      .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
      .frame_done(frame_done), .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint val;
      bit     last;
      bit     sat;
      longint cyc;
   } exp_t;

   exp_t               exp_q[$];
   logic signed [15:0] nmem [0:(1<<AW)-1];
   int                 n_checks = 0;
   int                 n_fail = 0;
   longint             cyc = 0;
   longint             idx = 0;
   longint             sat_exp = 0;
   int                 fd_cnt = 0;
   bit                 lat_mode = 1'b1;
   bit                 stop_rdy = 1'b0;

   always @(posedge clk) if (noise_en) noise_data <= nmem[noise_addr];
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint floor_div(input longint a, input longint b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   function automatic longint ref_pixel(input longint d, input longint nd, input longint sc, output bit sat);
      longint r, n, v, a;
      r = floor_div(d + (longint'(1) << (FS - 1)), longint'(1) << FS);
      n = floor_div(nd * sc, 256);
      v = r + n;
      a = (v >= 0) ? v : floor_div(v * 13, 64);
      sat = 1'b1;
      if (a > 32767) return 32767;
      if (a < -32768) return -32768;
      sat = 1'b0;
      return a;
   endfunction

   // Scoreboard: predicts each accepted beat and checks every output cycle against the queue head.
   always @(negedge clk) begin
      exp_t   e;
      longint nd;
      if (!rst_n) begin
         exp_q.delete();
         idx     = 0;
         sat_exp = 0;
      end else begin
         check("sat_count", sat_count, sat_exp);
         check("s_ready", s_ready, !(m_valid && !m_ready));
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               check("data", m_data, exp_q[0].val);
               check("last", m_last, exp_q[0].last);
               check("frame_done", frame_done, m_ready && exp_q[0].last);
               if (m_ready) begin
                  if (lat_mode) check("latency", cyc - exp_q[0].cyc, 3);
                  if (exp_q[0].sat && sat_exp < 65535) sat_exp++;
                  $display("beat out=%0d exp=%0d last=%0d", m_data, exp_q[0].val, m_last);
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            check("frame_done_idle", frame_done, 0);
         end
         if (frame_done) fd_cnt++;
         if (s_valid && s_ready) begin
`ifdef CONV_POSTPROC_NOISE_EN
            check("noise_en", noise_en, 1);
            check("noise_addr", noise_addr, idx);
            nd = longint'(nmem[idx]);
`else
            check("noise_en_off", noise_en, 0);
            check("noise_addr_off", noise_addr, 0);
            nd = 0;
`endif
            e.val  = ref_pixel(longint'(s_data), nd, longint'(noise_scale), e.sat);
            e.last = s_last;
            e.cyc  = cyc;
            exp_q.push_back(e);
            idx = s_last ? 0 : (idx + 1) % (longint'(1) << AW);
         end
      end
   end

   task automatic send(input longint d, input bit last);
      bit done;
      done    = 1'b0;
      s_valid = 1'b1;
      s_data  = d[RW-1:0];
      s_last  = last;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         done = s_ready;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic expect_out(input string tag, input longint exp);
      bit found;
      found = 1'b0;
      for (int t = 0; t < 30 && !found; t++) begin
         @(negedge clk);
         found = m_valid;
      end
      if (found) check(tag, m_data, exp);
      else check({tag, "_timeout"}, 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int t = 0; t < 300; t++) begin
         if (exp_q.size() == 0 && !m_valid) break;
         @(negedge clk);
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint d;
      int     vcount;
      for (int i = 0; i < (1 << AW); i++) nmem[i] = 16'($urandom_range(0, 65535));

      repeat (3) @(posedge clk); #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_m_data", m_data, 0);
      check("rst_sat_count", sat_count, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_noise_en", noise_en, 0);
      check("rst_noise_addr", noise_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", s_ready, 1);
      @(posedge clk); #1;

      send(25600, 1'b1);
      expect_out("round_pos", 100);
      send(-25600, 1'b1);
      expect_out("leaky_neg", -21);
      drain();
      check("sat_count_zero", sat_count, 0);
      send(longint'(1) << 40, 1'b1);
      expect_out("sat_pos", 32767);
      @(negedge clk);
      check("sat_count_one", sat_count, 1);
      @(posedge clk); #1;

`ifdef CONV_POSTPROC_NOISE_EN
      nmem[0]     = 16'sd256;
      noise_scale = 16'sd512;
      send(0, 1'b1);
      expect_out("noise_add", 512);
      drain();
      noise_scale = 16'sd0;
`endif

      fd_cnt = 0;
      for (int k = 0; k < 4; k++) send(longint'(1000 * (k + 1)), k == 3);
      drain();
      check("frame_done_count", fd_cnt, 1);
      check("addr_after_frame", noise_addr, 0);

      lat_mode = 1'b0;
      fork
         begin
            for (int k = 0; k < 8; k++) send(longint'(-3000 + 1500 * k), k == 7);
         end
         begin
            repeat (2) @(posedge clk);
            #1 m_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               if (k >= 2) check("ready_drop_on_stall", s_ready, 0);
               @(posedge clk); #1;
            end
            m_ready = 1'b1;
         end
      join
      drain();

      for (int k = 0; k < 3; k++) send(longint'(7000 + 2560 * k), 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_m_valid", m_valid, 0);
      check("midrst_m_data", m_data, 0);
      check("midrst_sat_count", sat_count, 0);
      check("midrst_noise_addr", noise_addr, 0);
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready_after", s_ready, 1);
      vcount = 0;
      for (int t = 0; t < 10; t++) begin
         if (m_valid) vcount++;
         @(negedge clk);
      end
      check("no_stale_beat", vcount, 0);
      @(posedge clk); #1;

      noise_scale = 16'($urandom_range(0, 2047) - 1024);
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               if ($urandom_range(0, 9) == 0) d = longint'($urandom_range(0, 1 << 30)) << 10;
               else d = longint'($urandom_range(0, 1 << 22));
               if ($urandom_range(0, 1) == 1) d = -d;
               send(d, $urandom_range(0, 6) == 0);
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk); #1;
               end
            end
            stop_rdy = 1'b1;
         end
         begin
            while (!stop_rdy) begin
               @(posedge clk); #1;
               m_ready = ($urandom_range(0, 3) != 0);
            end
            m_ready = 1'b1;
         end
      join
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
